// File: rtl/vga_pkg.sv
// Shared types for the VGA receive decoder: geometry defaults, FSM states,
// the 11-bit coordinate type and saturating counter helpers.
package vga_pkg;

    localparam int W_RES_DEF = 640;
    localparam int H_RES_DEF = 480;
    localparam int COORD_W   = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    function automatic coord_t coord_sat_inc(input coord_t v);
        return (v == 11'd2047) ? v : v + 11'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vga_rx_edge_sync.sv
// Previous-sample registers for HS, VS and BLANK_N with edge pulses that are
// only ever asserted on clocks where pix_en is high.
module vga_rx_edge_sync (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic pix_en,
    input  logic VGA_HS,
    input  logic VGA_VS,
    input  logic VGA_BLANK_N,
    output logic hs_rise_s,
    output logic hs_fall_s,
    output logic vs_fall_s,
    output logic blank_rise_s,
    output logic blank_fall_s
);

    logic hs_prev_r;
    logic vs_prev_r;
    logic blank_prev_r;

    // Hold the last pix_en-qualified sample of each timing input
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hs_prev_r    <= 1'b0;
            vs_prev_r    <= 1'b0;
            blank_prev_r <= 1'b0;
        end else if (pix_en) begin
            hs_prev_r    <= VGA_HS;
            vs_prev_r    <= VGA_VS;
            blank_prev_r <= VGA_BLANK_N;
        end
    end

    // Compare the current sample against the stored one
    always_comb begin
        hs_rise_s    = pix_en & ~hs_prev_r & VGA_HS;
        hs_fall_s    = pix_en & hs_prev_r & ~VGA_HS;
        vs_fall_s    = pix_en & vs_prev_r & ~VGA_VS;
        blank_rise_s = pix_en & ~blank_prev_r & VGA_BLANK_N;
        blank_fall_s = pix_en & blank_prev_r & ~VGA_BLANK_N;
    end

endmodule

// File: rtl/vga_rx_decoder.sv
// Recovers pixel coordinates from VGA timing, checks geometry and tracks lock.
// Optional VGA_RX_CHECKSUM_EN adds a per-frame (R+G+B) checksum output.
module vga_rx_decoder
    import vga_pkg::*;
#(
    parameter int W_RES       = W_RES_DEF,
    parameter int H_RES       = H_RES_DEF,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT_PIX = 500000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_N,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    output logic [10:0] x_coord,
    output logic [10:0] y_coord,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic [7:0]  err_count
`ifdef VGA_RX_CHECKSUM_EN
    ,
    output logic [23:0] frame_checksum
`endif
);

    localparam int               WD_W    = $clog2(TIMEOUT_PIX + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_PIX);
    localparam coord_t           W_LEN   = coord_t'(W_RES);
    localparam coord_t           H_LEN   = coord_t'(H_RES);
    localparam logic [7:0]       LOCK_N  = 8'(LOCK_FRAMES);

    logic hs_rise_s, hs_fall_s, vs_fall_s, blank_rise_s, blank_fall_s;
    logic unused_hs_s;

    rx_state_t        state_r;
    coord_t           x_cnt_r, y_cnt_r, pix_x_s, y_eff_s;
    logic [7:0]       good_cnt_r;
    logic [WD_W-1:0]  wd_r, wd_next_s;
    logic             frame_bad_r, line_bad_s, frame_good_s, timeout_s;

    vga_rx_edge_sync u_edge (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .pix_en       (pix_en),
        .VGA_HS       (VGA_HS),
        .VGA_VS       (VGA_VS),
        .VGA_BLANK_N  (VGA_BLANK_N),
        .hs_rise_s    (hs_rise_s),
        .hs_fall_s    (hs_fall_s),
        .vs_fall_s    (vs_fall_s),
        .blank_rise_s (blank_rise_s),
        .blank_fall_s (blank_fall_s)
    );

    // HS edges carry no geometry information here; geometry comes from BLANK_N
    assign unused_hs_s = hs_rise_s ^ hs_fall_s;

    // Per-sample decode; a coincident BLANK_N fall is folded into y before the frame check
    always_comb begin
        pix_x_s      = blank_rise_s ? coord_t'(0) : x_cnt_r;
        y_eff_s      = blank_fall_s ? coord_sat_inc(y_cnt_r) : y_cnt_r;
        line_bad_s   = blank_fall_s && (x_cnt_r != W_LEN);
        frame_good_s = (y_eff_s == H_LEN) && !frame_bad_r && !line_bad_s;
        wd_next_s    = wd_r + WD_W'(1);
        timeout_s    = pix_en && !vs_fall_s && (wd_next_s == WD_LAST);
    end

    // Counters, watchdog, pixel re-emission and error pulses
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x_cnt_r     <= '0;
            y_cnt_r     <= '0;
            wd_r        <= '0;
            frame_bad_r <= 1'b0;
            x_coord     <= '0;
            y_coord     <= '0;
            pix_r       <= 8'd0;
            pix_g       <= 8'd0;
            pix_b       <= 8'd0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            if (pix_en) begin
                frame_start <= vs_fall_s;
                line_err    <= line_bad_s;
                frame_err   <= timeout_s ||
                               (vs_fall_s && (state_r != SEARCH) && (y_eff_s != H_LEN));
                if (VGA_BLANK_N) begin
                    x_cnt_r     <= coord_sat_inc(pix_x_s);
                    x_coord     <= pix_x_s;
                    y_coord     <= y_cnt_r;
                    pix_r       <= VGA_R;
                    pix_g       <= VGA_G;
                    pix_b       <= VGA_B;
                    pixel_valid <= (state_r == LOCKED);
                end
                if (vs_fall_s) begin
                    y_cnt_r     <= '0;
                    frame_bad_r <= 1'b0;
                end else begin
                    if (blank_fall_s) y_cnt_r <= coord_sat_inc(y_cnt_r);
                    if (line_bad_s)   frame_bad_r <= 1'b1;
                end
                wd_r <= (vs_fall_s || timeout_s) ? '0 : wd_next_s;
            end
        end
    end

    // Lock FSM; timeout overrides every state, errors beat the locking transition
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r    <= SEARCH;
            good_cnt_r <= 8'd0;
            locked     <= 1'b0;
            err_count  <= 8'd0;
        end else if (pix_en) begin
            if (timeout_s) begin
                state_r    <= SEARCH;
                good_cnt_r <= 8'd0;
                locked     <= 1'b0;
                if (state_r == LOCKED) err_count <= sat_inc8(err_count);
            end else begin
                case (state_r)
                    SEARCH: begin
                        if (vs_fall_s) begin
                            state_r    <= TRAIN;
                            good_cnt_r <= 8'd0;
                        end
                    end
                    TRAIN: begin
                        if (vs_fall_s) begin
                            if (!frame_good_s) begin
                                good_cnt_r <= 8'd0;
                            end else if ((good_cnt_r + 8'd1) >= LOCK_N) begin
                                state_r    <= LOCKED;
                                good_cnt_r <= 8'd0;
                                locked     <= 1'b1;
                            end else begin
                                good_cnt_r <= good_cnt_r + 8'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (line_bad_s || (vs_fall_s && !frame_good_s)) begin
                            state_r   <= SEARCH;
                            locked    <= 1'b0;
                            err_count <= sat_inc8(err_count);
                        end
                    end
                    default: begin
                        state_r    <= SEARCH;
                        good_cnt_r <= 8'd0;
                        locked     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [23:0] cks_acc_r;
    logic [23:0] rgb_sum_s;

    assign rgb_sum_s = 24'(VGA_R) + 24'(VGA_G) + 24'(VGA_B);

    // Running colour sum, latched and restarted at each VS fall
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cks_acc_r      <= 24'd0;
            frame_checksum <= 24'd0;
        end else if (pix_en) begin
            if (vs_fall_s) begin
                frame_checksum <= cks_acc_r;
                cks_acc_r      <= VGA_BLANK_N ? rgb_sum_s : 24'd0;
            end else if (VGA_BLANK_N) begin
                cks_acc_r      <= cks_acc_r + rgb_sum_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Scoreboard bench for vga_rx_decoder using a reduced 24x13 raster (16x8 active).
module tb_vga_rx_decoder;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int TO = 1000;
    localparam int HT = 24;
    localparam int VT = 13;
    localparam int VA = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset, pix_en, VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic [10:0] x_coord, y_coord;
    logic [7:0]  pix_r, pix_g, pix_b, err_count;
    logic        pixel_valid, frame_start, locked, line_err, frame_err;
`ifdef VGA_RX_CHECKSUM_EN
    logic [23:0] frame_checksum;
`endif

    always #5 CLOCK_50 = ~CLOCK_50;

    vga_rx_decoder #(.W_RES(W), .H_RES(H), .LOCK_FRAMES(2), .TIMEOUT_PIX(TO)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .pix_en(pix_en),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .x_coord(x_coord), .y_coord(y_coord),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pixel_valid(pixel_valid), .frame_start(frame_start), .locked(locked),
        .line_err(line_err), .frame_err(frame_err), .err_count(err_count)
`ifdef VGA_RX_CHECKSUM_EN
        , .frame_checksum(frame_checksum)
`endif
    );

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } pix_t;

    typedef struct packed {
        logic        fs;
        logic        le;
        logic        fe;
        logic        lk;
        logic [7:0]  ec;
        logic [23:0] cks;
    } evt_t;

    pix_t        pix_q[$];
    evt_t        evt_q[$];
    pix_t        pe;
    evt_t        ee;
    int          checks = 0;
    int          fails  = 0;
    int          since_vs;
    logic        prev_vs_drv;
    logic [23:0] acc_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a pixel or an event pulse
    always @(negedge CLOCK_50) begin
        if (pixel_valid) begin
            if (pix_q.size() == 0) begin
                chk("pix_unexpected", 32'd1, 32'd0);
            end else begin
                pe = pix_q.pop_front();
                chk("pix_x", x_coord, pe.x);
                chk("pix_y", y_coord, pe.y);
                chk("pix_r", pix_r, pe.r);
                chk("pix_g", pix_g, pe.g);
                chk("pix_b", pix_b, pe.b);
            end
        end
        if (frame_start || line_err || frame_err) begin
            if (evt_q.size() == 0) begin
                chk("evt_unexpected", {frame_start, line_err, frame_err}, 32'd0);
            end else begin
                ee = evt_q.pop_front();
                chk("evt_frame_start", frame_start, ee.fs);
                chk("evt_line_err", line_err, ee.le);
                chk("evt_frame_err", frame_err, ee.fe);
                chk("evt_locked", locked, ee.lk);
                chk("evt_err_count", err_count, ee.ec);
`ifdef VGA_RX_CHECKSUM_EN
                if (ee.fs) chk("frame_checksum", frame_checksum, ee.cks);
`endif
            end
        end
    end

    task automatic sample(input logic hs, input logic vs, input logic bn,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        VGA_HS = hs; VGA_VS = vs; VGA_BLANK_N = bn;
        VGA_R = r; VGA_G = g; VGA_B = b;
        pix_en = 1'b1;
        if (prev_vs_drv && !vs) begin
            since_vs = 0;
            acc_m    = 24'd0;
        end else begin
            since_vs++;
            if (since_vs == TO) since_vs = 0;
        end
        if (bn) acc_m = acc_m + 24'(r) + 24'(g) + 24'(b);
        prev_vs_drv = vs;
        @(posedge CLOCK_50); #1;
        pix_en = 1'b0;
        // Garbage on idle clocks must never be sampled
        repeat ($urandom_range(0, 1)) begin
            VGA_HS = ~VGA_HS; VGA_VS = ~VGA_VS; VGA_BLANK_N = ~VGA_BLANK_N;
            @(posedge CLOCK_50); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; pix_en = 1'b0;
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        since_vs = 0; prev_vs_drv = 1'b0; acc_m = 24'd0;
        chk("rst_outputs", {pixel_valid, frame_start, locked, line_err, frame_err}, 32'd0);
        chk("rst_coords", {x_coord, y_coord}, 32'd0);
        chk("rst_colour", {pix_r, pix_g, pix_b}, 32'd0);
        chk("rst_err_count", err_count, 32'd0);
`ifdef VGA_RX_CHECKSUM_EN
        chk("rst_checksum", frame_checksum, 32'd0);
`endif
    endtask

    task automatic idle_line();
        for (int c = 0; c < HT; c++) sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    // One raster frame starting with its VS fall; optional short line or mid-frame reset
    task automatic send_frame(input bit pv, input int short_line, input int rst_line,
                              input bit fs_lk, input logic [7:0] fs_ec, input logic [7:0] le_ec);
        bit v;
        v = pv;
        for (int ln = 0; ln < VT; ln++) begin
            for (int c = 0; c < HT; c++) begin
                int   ay, len;
                bit   act;
                logic hs, vs, bn;
                logic [7:0] r, g, b;
                ay  = ln - VA;
                act = (ln >= VA) && (ln < VA + H);
                len = (ay == short_line) ? W - 1 : W;
                vs  = (ln >= 2);
                hs  = !(c >= 18 && c < 22);
                bn  = act && (c < len);
                r = 8'd0; g = 8'd0; b = 8'd0;
                if (bn) begin
                    if (c == 0 && ay == 0)              r = 8'h12;
                    else if (c == W - 1 && ay == H - 1) r = 8'hFF;
                    else                                r = 8'(c * 16 + ay);
                    g = 8'(c + 100);
                    b = 8'(ay + 7);
                end
                if (ln == 0 && c == 0)
                    evt_q.push_back('{fs: 1'b1, le: 1'b0, fe: 1'b0, lk: fs_lk, ec: fs_ec, cks: acc_m});
                if (bn && v)
                    pix_q.push_back('{x: 11'(c), y: 11'(ay), r: r, g: g, b: b});
                if (act && ay == short_line && c == len) begin
                    evt_q.push_back('{fs: 1'b0, le: 1'b1, fe: 1'b0, lk: 1'b0, ec: le_ec, cks: 24'd0});
                    v = 1'b0;
                end
                sample(hs, vs, bn, r, g, b);
                if (act && ay == rst_line && c == W + 1) do_reset();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pix_en = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_N = 1'b0;
        VGA_R = 8'd0; VGA_G = 8'd0; VGA_B = 8'd0;
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        do_reset();

        // Acquire lock, locked frame with corner pixels, short line, relock
        idle_line();
        send_frame(1'b0, -1, -1, 1'b0, 8'd0, 8'd0);
        send_frame(1'b0, -1, -1, 1'b0, 8'd0, 8'd0);
        send_frame(1'b1, -1, -1, 1'b1, 8'd0, 8'd0);
        send_frame(1'b1,  3, -1, 1'b1, 8'd0, 8'd1);
        send_frame(1'b0, -1, -1, 1'b0, 8'd1, 8'd0);
        send_frame(1'b0, -1, -1, 1'b0, 8'd1, 8'd0);
        send_frame(1'b1, -1, -1, 1'b1, 8'd1, 8'd0);

        // Watchdog: no VS fall while locked
        while (since_vs != TO - 1) sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        evt_q.push_back('{fs: 1'b0, le: 1'b0, fe: 1'b1, lk: 1'b0, ec: 8'd2, cks: 24'd0});
        sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);

        // Mid-frame reset discards the partial frame
        idle_line();
        send_frame(1'b0, -1, -1, 1'b0, 8'd2, 8'd0);
        send_frame(1'b0, -1,  4, 1'b0, 8'd2, 8'd0);
        send_frame(1'b0, -1, -1, 1'b0, 8'd0, 8'd0);
        send_frame(1'b0, -1, -1, 1'b0, 8'd0, 8'd0);
        send_frame(1'b1, -1, -1, 1'b1, 8'd0, 8'd0);
        idle_line();
        repeat (4) @(posedge CLOCK_50);
        #1;
        chk("final_locked", locked, 32'd1);
        chk("pix_q_drained", pix_q.size(), 32'd0);
        chk("evt_q_drained", evt_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
